// File: rtl/data_mem_io.sv
// Data-side memory for the single-cycle core: word RAM plus a memory-mapped
// TX FIFO draining to an external consumer. Loads are combinational.
module data_mem_io #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(4 * DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES   = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFF4;
  localparam logic [PW:0] FULL_COUNT  = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;

  logic          is_ram;
  logic          is_txdata;
  logic          is_status;
  logic [AW-3:0] word_idx;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic [31:0]   status;

  // Word addressing: the two low address bits are simply ignored.
  assign is_ram    = address_to_mem < RAM_BYTES;
  assign is_txdata = {address_to_mem[31:2], 2'b00} == TXDATA_ADDR;
  assign is_status = {address_to_mem[31:2], 2'b00} == STATUS_ADDR;
  assign word_idx  = address_to_mem[AW-1:2];

  assign full  = count == FULL_COUNT;
  assign empty = count == '0;

  // Handshake: a word moves on every cycle where tx_valid and tx_ready are both
  // high; tx_data is the FIFO head and stays put until that happens.
  assign tx_valid = !empty;
  assign tx_data  = fifo[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push_req = WE && is_txdata;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  assign status = {16'b0, {(7 - PW){1'b0}}, count, 5'b0, overflow, full, empty};

  always_comb begin
    data_from_mem = 32'b0;
    if (is_ram) begin
      data_from_mem = mem[word_idx];
    end else if (is_status) begin
      data_from_mem = status;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && WE && is_ram) begin
      mem[word_idx] <= data_to_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo[wr_ptr] <= data_to_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
      // A dropped push outranks a clearing STATUS write.
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (WE && is_status) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: RAM round-trip, FIFO ordering, overflow,
// full-with-pop, pointer wrap and mid-operation reset.
module tb_data_mem_io;

  localparam logic [31:0] TXDATA = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  data_mem_io #(.DEPTH_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    WE = 1'b1;
    address_to_mem = addr;
    data_to_mem = data;
    step();
    WE = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    WE = 1'b0;
    address_to_mem = addr;
    #1;
    check(tag, data_from_mem, exp);
  endtask

  task automatic drain(input string tag);
    logic [31:0] exp;
    tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      #1;
      check({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
      check({tag, "_data"}, tx_data, exp);
      step();
    end
    tx_ready = 1'b0;
    #1;
    check({tag, "_empty"}, {31'b0, tx_valid}, 32'd0);
  endtask

  initial begin
    int got;
    reset = 1'b1;
    WE = 1'b0;
    address_to_mem = 32'b0;
    data_to_mem = 32'b0;
    tx_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("reset_valid", {31'b0, tx_valid}, 32'd0);
    read_check("reset_status", STATUS, 32'h0000_0001);

    // RAM round trip, aliasing, out of range, read-during-write
    write(32'h0000_0008, 32'hDEAD_BEEF);
    read_check("ram_rd", 32'h0000_0008, 32'hDEAD_BEEF);
    read_check("ram_alias", 32'h0000_0009, 32'hDEAD_BEEF);
    read_check("ram_oob", 32'h0000_0200, 32'h0);
    read_check("txdata_rd", TXDATA, 32'h0);
    WE = 1'b1;
    address_to_mem = 32'h0000_0008;
    data_to_mem = 32'h1234_5678;
    #1;
    check("rdw_old", data_from_mem, 32'hDEAD_BEEF);
    step();
    WE = 1'b0;
    read_check("rdw_new", 32'h0000_0008, 32'h1234_5678);
    write(32'h0000_0010, 32'hCAFE_F00D);

    // FIFO ordering
    for (int i = 1; i <= 3; i++) begin
      write(TXDATA, 32'(i));
      exp_q.push_back(32'(i));
    end
    #1;
    check("ord_valid", {31'b0, tx_valid}, 32'd1);
    check("ord_head", tx_data, 32'd1);
    read_check("ord_status", STATUS, 32'h0000_0300);
    drain("ord");
    read_check("ord_status_end", STATUS, 32'h0000_0001);

    // Overflow: 10..13 kept, 14 and 15 dropped
    for (int i = 10; i <= 15; i++) begin
      write(TXDATA, 32'(i));
      if (i <= 13) exp_q.push_back(32'(i));
    end
    read_check("ovf_status", STATUS, 32'h0000_0406);
    write(STATUS, 32'hFFFF_FFFF);
    read_check("ovf_clear", STATUS, 32'h0000_0402);

    // Full with simultaneous pop: 10 leaves, 0x55 enters
    tx_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(32'h55);
    write(TXDATA, 32'h55);
    tx_ready = 1'b0;
    read_check("fullpop_status", STATUS, 32'h0000_0402);
    drain("fullpop");

    // Pointer wrap: push on even cycles, ready high on odd cycles
    got = 0;
    for (int i = 0; i < 60 && got < 10; i++) begin
      tx_ready = (i % 2) == 1;
      WE = 1'b0;
      if ((i % 2) == 0 && i / 2 < 10) begin
        WE = 1'b1;
        address_to_mem = TXDATA;
        data_to_mem = 32'h100 + 32'(i / 2);
        exp_q.push_back(data_to_mem);
      end
      #1;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("wrap_unexpected", tx_data, 32'hFFFF_FFFF);
        end else begin
          check("wrap_data", tx_data, exp_q.pop_front());
        end
        got++;
      end
      step();
    end
    WE = 1'b0;
    tx_ready = 1'b0;
    check("wrap_count", 32'(got), 32'd10);
    read_check("wrap_status", STATUS, 32'h0000_0001);
    exp_q.delete();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) write(TXDATA, 32'h200 + 32'(i));
    reset = 1'b1;
    WE = 1'b1;
    address_to_mem = TXDATA;
    data_to_mem = 32'h77;
    step();
    reset = 1'b0;
    WE = 1'b0;
    #1;
    check("rst_valid", {31'b0, tx_valid}, 32'd0);
    read_check("rst_status", STATUS, 32'h0000_0001);
    read_check("rst_ram", 32'h0000_0010, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory block directly downstream of the single-cycle processor. It consumes the processor's `WE`, `address_to_mem` and `data_to_mem`, and returns `data_from_mem` combinationally in the same cycle. It holds a word-addressed data RAM plus a memory-mapped transmit FIFO that drains to an external consumer over a valid/ready handshake. The processor cannot stall, so every access completes in the cycle it is issued.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: data RAM size in 32-bit words; power of two, at most 1024.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2 to 16.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `WE`  in  1  write enable from the processor.
- `address_to_mem`  in  32  byte address from the processor.
- `data_to_mem`  in  32  store data from the processor.
- `data_from_mem`  out  32  load data to the processor; combinational.
- `tx_data`  out  32  FIFO head word.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head word.

## Operation
- Address map. Bits [1:0] are ignored: all accesses are word accesses with no misalignment fault.
  - RAM: `address_to_mem < 4*DEPTH_WORDS`, word index `address_to_mem[log2(4*DEPTH_WORDS)-1:2]`.
  - TXDATA: `0xFFFF_FFF0`. Write pushes `data_to_mem`. Read returns 0.
  - STATUS: `0xFFFF_FFF4`. Read returns `{16'b0, count[7:0], 5'b0, overflow, full, empty}`. Any write clears `overflow`; the written data is ignored.
  - Any other address: read returns 0, write has no effect.
- RAM: combinational read, synchronous write on `WE` at a RAM address. Contents are not cleared by reset.
- FIFO: first-word-fall-through ring buffer with read pointer, write pointer and `count`.
  - `tx_valid = (count != 0)`.
  - `tx_data` = entry at the read pointer.
- Pop occurs when `tx_valid & tx_ready`.
- Push is requested when `WE` is high and the address is TXDATA.
  - The push is accepted if `count < FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set. `overflow` is sticky.
- Simultaneous accepted push and pop: both pointers advance and `count` is unchanged. This includes the full case.
- Pointers wrap modulo `FIFO_DEPTH`.
- `full = (count == FIFO_DEPTH)`; `empty = (count == 0)`.
- A STATUS write in the same cycle as an overflowing push: the set wins, so `overflow` ends at 1. This cannot happen from a single processor, because only one address is presented per cycle; the rule is given for completeness.

## Timing
- Reset: when `reset` is sampled high, `count`, both pointers and `overflow` become 0, and the RAM and FIFO writes of that cycle are suppressed.
  - Output values after reset: `tx_valid=0`, `tx_data` undefined (don't-care while invalid), `data_from_mem` follows the current address.
  - Reset mid-drain discards all queued words; the consumer must not expect them.
- Load latency is 0 cycles: `data_from_mem` is valid in the same cycle as the address.
- Read-during-write to the same RAM word returns the old data. The new data is visible the next cycle.
- A push becomes visible on `tx_valid`/`tx_data` the cycle after the `WE` edge, so FIFO latency is 1 cycle.
- A STATUS read reflects the registered state before the current cycle's edge.
- `tx_data` must be held stable while `tx_valid & !tx_ready`.
- The consumer may change `tx_ready` freely. A word is transferred only on a cycle where `tx_valid` and `tx_ready` are both high.

## Test plan
- RAM round-trip:
  - Write `0xDEAD_BEEF` to `0x0000_0008`, then read `0x0000_0008` → `0xDEAD_BEEF`.
  - Read `0x0000_0009` → same word.
  - Read `0x0000_0200` (out of range) → 0.
- FIFO ordering with `tx_ready=0`:
  - Push 1, 2, 3 → `tx_valid=1`, `tx_data=1`, STATUS = `0x0000_0300`.
  - Raise `tx_ready` → `tx_data` shows 1, 2, 3 on consecutive cycles, then `tx_valid=0` and STATUS = `0x0000_0001`.
- Overflow (DEPTH 4, `tx_ready=0`):
  - Push 10..15 → 10..13 are queued, 14 and 15 are dropped, STATUS = `0x0000_0406`.
  - Write STATUS → `overflow` is cleared and STATUS = `0x0000_0402`.
- Full with simultaneous pop:
  - With 4 queued and `tx_ready=1`, push `0x55` → `count` stays 4, no overflow, and `0x55` drains fifth.
- Pointer wrap:
  - Push/pop 10 words through DEPTH 4 with `tx_ready` toggling every cycle → output order matches input order and no words are lost.
- Reset mid-operation:
  - Queue 3 words, assert `reset` for one cycle while pushing `0x77` → `tx_valid=0`, STATUS = `0x0000_0001`.
  - RAM word previously written still reads back unchanged.
